// File: rtl/spi_master.sv
// spi_master: multi-word SPI master with runtime CPOL/CPHA, chip-select mask, word count and abort.
module spi_master #(
  parameter int CLK_DIV = 10,
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 4,
  parameter int LEN_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [NUM_CS-1:0] cs_mask,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [EW-1:0] ecnt;
  logic [LEN_W-1:0] wcnt, len_l;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic cpol_l, cpha_l, abort_l;
  logic tick, last_edge, stop, shift;
  always_comb begin
    tick = cnt == CW'(CLK_DIV - 1);
    last_edge = ecnt == EW'(2 * DATA_W - 1);
    stop = (wcnt == len_l - LEN_W'(1)) || abort_l || abort;
    shift = cpha_l ? !ecnt[0] : ecnt[0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ecnt <= '0;
      wcnt <= '0;
      len_l <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      abort_l <= 1'b0;
      cs_n <= '1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      rx_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            len_l <= len;
            tx_sr <= tx_data;
            mosi <= tx_data[DATA_W-1];
            ecnt <= '0;
            wcnt <= '0;
            abort_l <= 1'b0;
            busy <= 1'b1;
            cs_n <= (len == '0) ? '1 : ~cs_mask;
            tx_ready <= len != '0;
            done <= len == '0;
            state <= (len == '0) ? GAP : SETUP;
          end
        end
        SETUP: begin
          abort_l <= abort_l || abort;
          if (tick) state <= XFER;
        end
        XFER: begin
          abort_l <= abort_l || abort;
          if (tick) begin
            sclk <= ~sclk;
            ecnt <= ecnt + EW'(1);
            if (!shift) rx_sr <= {rx_sr[DATA_W-2:0], miso};
            if (shift) begin
              tx_sr <= tx_sr << 1;
              mosi <= cpha_l ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
            end
            if (last_edge) begin
              ecnt <= '0;
              wcnt <= wcnt + LEN_W'(1);
              rx_data <= cpha_l ? {rx_sr[DATA_W-2:0], miso} : rx_sr;
              rx_valid <= 1'b1;
              abort_l <= 1'b0;
              if (stop) state <= HOLD;
              else begin
                tx_sr <= tx_data;
                tx_ready <= 1'b1;
                if (!cpha_l) mosi <= tx_data[DATA_W-1];
              end
            end
          end
        end
        HOLD: if (tick) begin
          cs_n <= '1;
          done <= 1'b1;
          state <= GAP;
        end
        GAP: if (tick) begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven and randomized transactions checked against an SPI slave model.
module tb_spi_master;
  localparam int CD = 10, DW = 8, NC = 4, LW = 3, PER = 2 * DW * CD;
  logic clk = 0, rst = 0, start = 0, abort = 0, cpol = 0, cpha = 0, miso_r = 0, loop = 0;
  logic [NC-1:0] cs_mask = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] tx_data = '0;
  logic tx_ready, rx_valid, busy, done, sclk, mosi, miso;
  logic [DW-1:0] rx_data;
  logic [NC-1:0] cs_n;
  int checks = 0, failures = 0;
  assign miso = loop ? mosi : miso_r;
  always #5 clk = ~clk;

  spi_master dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cpol(cpol), .cpha(cpha),
    .cs_mask(cs_mask), .len(len), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  typedef struct {
    bit cpol, cpha, loop, rnd, mid;
    logic [3:0] mask;
    int len, abort_at, exp_cs, exp_done;
    logic [63:0] words;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] words [8];
    logic [7:0] e;
    int rdy_c[$], rv_c[$], done_c[$];
    logic [7:0] rv_d[$];
    bit mbits[$], sbits[$];
    int leff, widx, cs_low, cs_bad, sclk_bad, busy_low, exp_cs, exp_done;
    bit cs_prev, sclk_prev, cs_act, lead;
    for (int k = 0; k < 8; k++) words[k] = v.rnd ? 8'($urandom) : v.words[63-8*k -: 8];
    leff = (v.abort_at >= 0 && v.abort_at < v.len) ? v.abort_at + 1 : v.len;
    exp_cs = v.exp_cs >= 0 ? v.exp_cs : (leff > 0 ? (2 + 2 * DW * leff) * CD : 0);
    exp_done = v.exp_done >= 0 ? v.exp_done : (leff > 0 ? exp_cs + 1 : 1);
    loop = v.loop; cpol = v.cpol; cpha = v.cpha; cs_mask = v.mask; len = LW'(v.len);
    widx = 0; tx_data = words[0];
    cs_low = 0; cs_bad = 0; sclk_bad = 0; busy_low = -1;
    repeat (2) @(negedge clk);
    start = 1; cs_prev = 0; sclk_prev = v.cpol;
    for (int c = 1; c <= 1300 && busy_low < 0; c++) begin
      @(negedge clk);
      start = v.mid && c == 50;
      cs_mask = (v.mid && c == 50) ? '1 : v.mask;
      len = (v.mid && c == 50) ? 3'd7 : LW'(v.len);
      abort = v.abort_at >= 0 && c == 51 + PER * v.abort_at;
      cs_act = cs_n != '1;
      if (cs_act) cs_low++;
      if (cs_act && cs_n != ~v.mask) cs_bad++;
      if (!cs_act && sclk != v.cpol) sclk_bad++;
      if (cs_act && !cs_prev && !v.cpha) begin miso_r = 1'($urandom); sbits.push_back(miso_r); end
      if (cs_act && sclk != sclk_prev) begin
        lead = sclk != v.cpol;
        if (lead ^ v.cpha) mbits.push_back(mosi);
        else begin miso_r = 1'($urandom); sbits.push_back(miso_r); end
      end
      sclk_prev = sclk; cs_prev = cs_act;
      if (tx_ready) begin rdy_c.push_back(c); if (widx < 7) widx++; tx_data = words[widx]; end
      if (rx_valid) begin rv_c.push_back(c); rv_d.push_back(rx_data); end
      if (done) done_c.push_back(c);
      if (!busy) busy_low = c;
    end
    abort = 0;
    chk("cs_low_cycles", cs_low, exp_cs);
    chk("cs_value", cs_bad, 0);
    chk("sclk_idle", sclk_bad, 0);
    chk("cs_idle_after", cs_n, 4'hF);
    chk("done_count", done_c.size(), 1);
    if (done_c.size() > 0) chk("done_cycle", done_c[0], exp_done);
    chk("busy_low_cycle", busy_low, exp_done + CD);
    chk("rx_valid_count", rv_c.size(), leff);
    chk("mosi_bits", mbits.size(), 8 * leff);
    if (leff > 0) begin
      chk("tx_ready_count", rdy_c.size(), leff);
      for (int k = 0; k < rdy_c.size() && k < leff; k++)
        chk("tx_ready_cycle", rdy_c[k], k == 0 ? 1 : CD + 1 + PER * k);
    end
    for (int k = 0; k < rv_c.size() && k < leff; k++) begin
      chk("rx_valid_cycle", rv_c[k], CD + 1 + PER * (k + 1));
      e = words[k];
      if (!v.loop) for (int j = 0; j < 8; j++) e = {e[6:0], (8 * k + j < sbits.size()) ? sbits[8*k+j] : 1'b0};
      chk("rx_data", rv_d[k], e);
    end
    for (int k = 0; k < leff && 8 * k + 7 < mbits.size(); k++) begin
      e = '0;
      for (int j = 0; j < 8; j++) e = {e[6:0], mbits[8*k+j]};
      chk("mosi_word", e, words[k]);
    end
  endtask

  initial begin
    vec_t vecs [7];
    vec_t r;
    vecs[0] = '{0, 0, 0, 0, 0, 4'b0001, 3, -1, 500, 501, 64'h0A2D020000000000};
    vecs[1] = '{1, 1, 1, 0, 0, 4'b0001, 2, -1, 340, 341, 64'hA53C000000000000};
    vecs[2] = '{0, 0, 0, 1, 0, 4'b0001, 0, -1, 0, 1, '0};
    vecs[3] = '{0, 1, 0, 1, 1, 4'b0100, 1, -1, 180, 181, '0};
    vecs[4] = '{0, 0, 0, 1, 0, 4'b0001, 5, 1, 340, 341, '0};
    vecs[5] = '{1, 0, 0, 1, 0, 4'b1010, 1, -1, 180, 181, '0};
    vecs[6] = '{0, 0, 0, 1, 0, 4'b1000, 7, -1, 1140, 1141, '0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cs_n, sclk, mosi, rx_data, busy, done, tx_ready, rx_valid}, {4'hF, 14'h0});
    rst = 1;
    @(negedge clk);
    chk("idle_after_reset", {cs_n, busy}, {4'hF, 1'b0});
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);
    for (int i = 0; i < 8; i++) begin
      r.cpol = 1'($urandom); r.cpha = 1'($urandom); r.loop = 1'($urandom); r.rnd = 1; r.mid = 0;
      r.mask = 4'($urandom_range(1, 15)); r.len = $urandom_range(0, 7);
      r.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      r.exp_cs = -1; r.exp_done = -1; r.words = '0;
      run_txn(r);
    end
    loop = 1; cpol = 0; cpha = 0; cs_mask = 4'b0001; len = 3'd3; tx_data = 8'h0A;
    repeat (2) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (199) @(negedge clk);
    chk("pre_reset_rx", rx_data, 8'h0A);
    chk("pre_reset_busy", busy, 1);
    rst = 0;
    #1;
    chk("mid_xfer_reset", {cs_n, sclk, mosi, rx_data, busy, done, tx_ready, rx_valid}, {4'hF, 14'h0});
    @(negedge clk);
    rst = 1;
    run_txn(vecs[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
